// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// pipe_ctrl : merges stall sources into a hold level, arbitrates branch and
//             interrupt redirects, and sequences the post-redirect flush.
// Revision  : 1.0
// ============================================================================
module pipe_ctrl #(
  parameter int ADDR_WIDTH   = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  bus_hold_i,
  input  logic                  div_busy_i,
  input  logic                  load_use_i,
  input  logic                  ex_jump_i,
  input  logic [ADDR_WIDTH-1:0] ex_jump_addr_i,
  input  logic                  int_req_i,
  input  logic [ADDR_WIDTH-1:0] int_addr_i,
  output logic                  int_ack_o,
  output logic [2:0]            hold_flag_o,
  output logic                  jump_flag_o,
  output logic [ADDR_WIDTH-1:0] jump_addr_o,
  output logic                  flush_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

  state_t                state;
  state_t                state_nxt;
  logic [2:0]            flush_cnt;
  logic [2:0]            flush_cnt_nxt;
  logic [ADDR_WIDTH-1:0] target;
  logic [ADDR_WIDTH-1:0] target_nxt;
  logic                  redirecting;
  logic                  int_accept;
  logic                  jump_accept;

  assign redirecting = (state == ST_ISSUE) || (state == ST_FLUSH);

  // Stalls raised by wrong-path instructions are ignored once a redirect is issuing.
  always_comb begin
    hold_flag_o = 3'd0;
    if (rst_i) begin
      hold_flag_o = 3'd0;
    end else if (bus_hold_i) begin
      hold_flag_o = 3'd4;
    end else if (!redirecting) begin
      if (div_busy_i) begin
        hold_flag_o = 3'd3;
      end else if (load_use_i) begin
        hold_flag_o = 3'd2;
      end
    end
  end

  assign int_accept  = (state == ST_IDLE) && int_req_i;
  assign jump_accept = (state == ST_IDLE) && ex_jump_i && !div_busy_i && !int_req_i;
  assign int_ack_o   = int_accept && !rst_i;

  assign jump_flag_o = (state == ST_ISSUE);
  assign flush_o     = redirecting;
  assign jump_addr_o = target;

  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    target_nxt    = target;
    case (state)
      ST_IDLE: begin
        if (int_accept || jump_accept) begin
          target_nxt = int_accept ? int_addr_i : ex_jump_addr_i;
          state_nxt  = bus_hold_i ? ST_PEND : ST_ISSUE;
        end
      end
      ST_PEND: begin
        if (!bus_hold_i) begin
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // pc_reg takes the jump in the first cycle the hold level is clear.
        if (!bus_hold_i) begin
          if (FLUSH_CYCLES == 1) begin
            state_nxt = ST_IDLE;
          end else begin
            state_nxt     = ST_FLUSH;
            flush_cnt_nxt = FLUSH_INIT;
          end
        end
      end
      ST_FLUSH: begin
        if (!bus_hold_i) begin
          flush_cnt_nxt = flush_cnt - 3'd1;
          if (flush_cnt == 3'd1) begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      flush_cnt <= 3'd0;
      target    <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
      target    <= target_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// tb_pipe_ctrl: two instances (flush window 2 and 5) driven in parallel and
// checked every cycle against a redirect-progress model, plus literal expectations.
module tb_pipe_ctrl;
  localparam int AW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, bus_hold, div_busy, load_use, ex_jump, int_req;
  logic [AW-1:0] ex_jump_addr, int_addr;

  logic          ack0, jflag0, flush0, ack1, jflag1, flush1;
  logic [2:0]    hold0, hold1;
  logic [AW-1:0] jaddr0, jaddr1;

  pipe_ctrl #(.ADDR_WIDTH(AW), .FLUSH_CYCLES(2)) u_fc2 (
    .clk_i(clk), .rst_i(rst), .bus_hold_i(bus_hold), .div_busy_i(div_busy),
    .load_use_i(load_use), .ex_jump_i(ex_jump), .ex_jump_addr_i(ex_jump_addr),
    .int_req_i(int_req), .int_addr_i(int_addr), .int_ack_o(ack0),
    .hold_flag_o(hold0), .jump_flag_o(jflag0), .jump_addr_o(jaddr0), .flush_o(flush0)
  );

  pipe_ctrl #(.ADDR_WIDTH(AW), .FLUSH_CYCLES(5)) u_fc5 (
    .clk_i(clk), .rst_i(rst), .bus_hold_i(bus_hold), .div_busy_i(div_busy),
    .load_use_i(load_use), .ex_jump_i(ex_jump), .ex_jump_addr_i(ex_jump_addr),
    .int_req_i(int_req), .int_addr_i(int_addr), .int_ack_o(ack1),
    .hold_flag_o(hold1), .jump_flag_o(jflag1), .jump_addr_o(jaddr1), .flush_o(flush1)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [AW-1:0] got, input logic [AW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: a redirect is either waiting for the bus, jumping, or has N flush cycles left.
  bit            m_wait [2];
  bit            m_jump [2];
  int            m_left [2];
  logic [AW-1:0] m_addr [2];
  bit            m_valid = 1'b0;

  function automatic int fc_of(input int i);
    return (i == 0) ? 2 : 5;
  endfunction

  function automatic bit m_idle(input int i);
    return !m_wait[i] && !m_jump[i] && (m_left[i] == 0);
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_wait[i] = 1'b0; m_jump[i] = 1'b0; m_left[i] = 0; m_addr[i] = '0;
      end else if (m_jump[i]) begin
        if (!bus_hold) begin
          m_jump[i] = 1'b0;
          m_left[i] = fc_of(i) - 1;
        end
      end else if (m_left[i] > 0) begin
        if (!bus_hold) m_left[i] = m_left[i] - 1;
      end else if (m_wait[i]) begin
        if (!bus_hold) begin
          m_wait[i] = 1'b0;
          m_jump[i] = 1'b1;
        end
      end else if (int_req || (ex_jump && !div_busy)) begin
        m_addr[i] = int_req ? int_addr : ex_jump_addr;
        if (bus_hold) m_wait[i] = 1'b1;
        else          m_jump[i] = 1'b1;
      end
    end
    m_valid = 1'b1;
  end

  task automatic cmp(input int i, input logic [2:0] h, input logic jf, input logic [AW-1:0] ja,
                     input logic fl, input logic ak);
    logic [2:0] eh;
    bit         busy;
    busy = m_jump[i] || (m_left[i] > 0);
    if (rst)           eh = 3'd0;
    else if (bus_hold) eh = 3'd4;
    else if (busy)     eh = 3'd0;
    else if (div_busy) eh = 3'd3;
    else if (load_use) eh = 3'd2;
    else               eh = 3'd0;
    check($sformatf("fc%0d hold_flag", fc_of(i)), AW'(h), AW'(eh));
    check($sformatf("fc%0d jump_flag", fc_of(i)), AW'(jf), AW'(m_jump[i]));
    check($sformatf("fc%0d jump_addr", fc_of(i)), ja, m_addr[i]);
    check($sformatf("fc%0d flush", fc_of(i)), AW'(fl), AW'(busy));
    check($sformatf("fc%0d int_ack", fc_of(i)), AW'(ak), AW'(!rst && m_idle(i) && int_req));
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      cmp(0, hold0, jflag0, jaddr0, flush0, ack0);
      cmp(1, hold1, jflag1, jaddr1, flush1, ack1);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus_hold = 0; div_busy = 0; load_use = 0; ex_jump = 0; int_req = 0;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) next_cycle();
  endtask

  typedef struct { logic b; logic d; logic l; logic [2:0] h; } hold_vec_t;
  hold_vec_t hv [6];

  initial begin
    hv[0] = '{1, 1, 1, 3'd4}; hv[1] = '{0, 1, 1, 3'd3}; hv[2] = '{0, 0, 1, 3'd2};
    hv[3] = '{0, 1, 0, 3'd3}; hv[4] = '{0, 0, 0, 3'd0}; hv[5] = '{1, 0, 1, 3'd4};

    rst = 1; bus_hold = 1; div_busy = 1; load_use = 1; ex_jump = 1; int_req = 1;
    ex_jump_addr = 32'h200; int_addr = 32'h80;

    // Reset with every request asserted
    for (int k = 0; k < 3; k++) begin
      sample();
      check("rst hold", AW'(hold0), 0);
      check("rst jump_flag", AW'(jflag0), 0);
      check("rst flush", AW'(flush0), 0);
      check("rst int_ack", AW'(ack0), 0);
      check("rst jump_addr", jaddr0, 0);
      next_cycle();
    end
    rst = 0; bus_hold = 0; div_busy = 0; load_use = 0;
    sample();
    check("post-rst int_ack", AW'(ack0), 1);
    next_cycle(); clear_inputs();
    sample();
    check("post-rst jump_flag", AW'(jflag0), 1);
    check("post-rst jump_addr", jaddr0, 32'h80);
    idle_cycles(6);

    // Plain branch
    ex_jump = 1; ex_jump_addr = 32'h100;
    sample();
    check("br accept ack", AW'(ack0), 0);
    next_cycle(); clear_inputs();
    sample();
    check("br jump_flag", AW'(jflag0), 1);
    check("br jump_addr", jaddr0, 32'h100);
    check("br flush n+1", AW'(flush0), 1);
    next_cycle();
    sample();
    check("br jump_flag n+2", AW'(jflag0), 0);
    check("br flush n+2", AW'(flush0), 1);
    next_cycle();
    sample();
    check("br flush n+3", AW'(flush0), 0);
    check("br addr held", jaddr0, 32'h100);
    idle_cycles(4);

    // Simultaneous interrupt and branch
    ex_jump = 1; ex_jump_addr = 32'h200; int_req = 1; int_addr = 32'h80;
    sample();
    check("sim int_ack", AW'(ack0), 1);
    next_cycle(); clear_inputs();
    sample();
    check("sim jump_flag", AW'(jflag0), 1);
    check("sim jump_addr", jaddr0, 32'h80);
    idle_cycles(6);
    sample();
    check("sim no 0x200 fc2", jaddr0, 32'h80);
    check("sim no 0x200 fc5", jaddr1, 32'h80);

    // Bus hold before and during issue
    next_cycle();
    ex_jump = 1; ex_jump_addr = 32'h300; bus_hold = 1;
    sample();
    check("pend hold", AW'(hold0), 4);
    next_cycle(); ex_jump = 0;
    sample();
    check("pend hold c2", AW'(hold0), 4);
    check("pend jump_flag c2", AW'(jflag0), 0);
    next_cycle();
    sample();
    check("pend jump_flag c3", AW'(jflag0), 0);
    next_cycle(); bus_hold = 0;
    sample();
    check("pend release jump_flag", AW'(jflag0), 0);
    check("pend release hold", AW'(hold0), 0);
    next_cycle(); bus_hold = 1;
    sample();
    check("issue held jump_flag", AW'(jflag0), 1);
    check("issue held hold", AW'(hold0), 4);
    check("issue held addr", jaddr0, 32'h300);
    next_cycle();
    sample();
    check("issue held jump_flag 2", AW'(jflag0), 1);
    next_cycle(); bus_hold = 0;
    sample();
    check("issue free jump_flag", AW'(jflag0), 1);
    next_cycle();
    sample();
    check("issue done jump_flag", AW'(jflag0), 0);
    check("issue done flush", AW'(flush0), 1);
    next_cycle();
    sample();
    check("hold window end flush", AW'(flush0), 0);
    idle_cycles(5);

    // Hold priority table in IDLE
    for (int k = 0; k < 6; k++) begin
      next_cycle();
      bus_hold = hv[k].b; div_busy = hv[k].d; load_use = hv[k].l;
      sample();
      check($sformatf("prio %0d fc2", k), AW'(hold0), AW'(hv[k].h));
      check($sformatf("prio %0d fc5", k), AW'(hold1), AW'(hv[k].h));
    end

    // Branch blocked by a busy divider
    next_cycle();
    clear_inputs(); div_busy = 1; ex_jump = 1; ex_jump_addr = 32'h500;
    sample();
    check("div block hold", AW'(hold0), 3);
    next_cycle(); clear_inputs();
    sample();
    check("div block jump_flag", AW'(jflag0), 0);
    check("div block addr", jaddr0, 32'h300);

    // Stalls masked while issuing and flushing
    next_cycle();
    ex_jump = 1; ex_jump_addr = 32'h400;
    next_cycle(); ex_jump = 0; load_use = 1; div_busy = 1;
    sample();
    check("mask issue jump_flag", AW'(jflag0), 1);
    check("mask issue hold", AW'(hold0), 0);
    next_cycle();
    sample();
    check("mask flush flush", AW'(flush0), 1);
    check("mask flush hold", AW'(hold0), 0);
    next_cycle(); clear_inputs();
    idle_cycles(5);

    // Reset in the second flush cycle of the 5-cycle instance
    ex_jump = 1; ex_jump_addr = 32'h600;
    next_cycle(); ex_jump = 0;
    sample();
    check("rf issue jump_flag", AW'(jflag1), 1);
    check("rf issue flush", AW'(flush1), 1);
    next_cycle(); rst = 1; bus_hold = 1;
    sample();
    check("rf flush 2nd", AW'(flush1), 1);
    check("rf rst hold", AW'(hold1), 0);
    next_cycle(); rst = 0; bus_hold = 0;
    sample();
    check("rf after flush", AW'(flush1), 0);
    check("rf after jump_flag", AW'(jflag1), 0);
    check("rf after addr", jaddr1, 0);
    idle_cycles(3);
    sample();
    check("rf late jump_flag", AW'(jflag1), 0);
    check("rf late flush", AW'(flush1), 0);

    next_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
